// File: rtl/acionador_bomba.sv
// -----------------------------------------------------------------------------
// acionador_bomba
//
// Pump actuation stage. It takes a run-time command in milliseconds and drives
// the pump for exactly that long, timing milliseconds from the system clock.
// A low-reservoir interlock and an operator abort both cut the pump within one
// cycle. Every run, abort or interlock trip is followed by a fixed rest
// interval before a new start is accepted.
//
// Parameters
//   TICKS_POR_MS  clock cycles per millisecond
//   TEMPO_MAX_MS  ceiling applied to accepted commands (16-bit unsigned)
//   PAUSA_MS      rest interval after every run, in ms
//
// Ports
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   iniciar             single-cycle start request, samples tempo_ms
//   tempo_ms[15:0]      requested run time in ms
//   alerta_nivel_baixo  low-reservoir alarm (level-sensitive interlock)
//   abortar             operator stop
//   bomba_on            pump drive (registered)
//   ocupado             high while running or resting
//   concluido           one-cycle pulse at the end of every run/refusal
//   falha               sticky interlock fault flag
//   tempo_restante_ms   remaining ms of the current run, 0 outside a run
// -----------------------------------------------------------------------------
module acionador_bomba #(
    parameter int TICKS_POR_MS = 50000,
    parameter int TEMPO_MAX_MS = 25000,
    parameter int PAUSA_MS     = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iniciar,
    input  logic [15:0] tempo_ms,
    input  logic        alerta_nivel_baixo,
    input  logic        abortar,
    output logic        bomba_on,
    output logic        ocupado,
    output logic        concluido,
    output logic        falha,
    output logic [15:0] tempo_restante_ms
);

    // A one-tick millisecond still needs a 1-bit prescaler.
    localparam int PW = (TICKS_POR_MS > 1) ? $clog2(TICKS_POR_MS) : 1;
    localparam logic [PW-1:0] PRESC_FIM = PW'(TICKS_POR_MS - 1);
    localparam logic [15:0]   TMAX      = 16'(TEMPO_MAX_MS);
    localparam logic [15:0]   PAUSA_CNT = 16'(PAUSA_MS);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        RUN    = 2'd1,
        PAUSA  = 2'd2
    } estado_t;

    estado_t        estado_q;
    logic [PW-1:0]  presc_q;
    logic [15:0]    restante_q;
    logic [15:0]    pausa_q;
    logic           bomba_q;
    logic           ocupado_q;
    logic           concluido_q;
    logic           falha_q;

    logic [15:0]    tempo_sat_d;
    logic           presc_fim_d;
    logic           fim_natural_d;

    // Unsigned clamp of the incoming command.
    assign tempo_sat_d   = (tempo_ms > TMAX) ? TMAX : tempo_ms;
    assign presc_fim_d   = (presc_q == PRESC_FIM);
    // The last millisecond expires on the prescaler terminal count with one
    // ms left, so the pump is on for exactly T*TICKS_POR_MS cycles.
    assign fim_natural_d = presc_fim_d && (restante_q == 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= OCIOSO;
            presc_q     <= '0;
            restante_q  <= '0;
            pausa_q     <= '0;
            bomba_q     <= 1'b0;
            ocupado_q   <= 1'b0;
            concluido_q <= 1'b0;
            falha_q     <= 1'b0;
        end else begin
            concluido_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (iniciar) begin
                        if (alerta_nivel_baixo) begin
                            // Refused start: flag it and report completion.
                            falha_q     <= 1'b1;
                            concluido_q <= 1'b1;
                        end else if (tempo_ms == 16'd0) begin
                            // Zero-length run completes without moving the pump.
                            falha_q     <= 1'b0;
                            concluido_q <= 1'b1;
                        end else begin
                            restante_q <= tempo_sat_d;
                            presc_q    <= '0;
                            falha_q    <= 1'b0;
                            bomba_q    <= 1'b1;
                            ocupado_q  <= 1'b1;
                            estado_q   <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (alerta_nivel_baixo || abortar || fim_natural_d) begin
                        // Alarm has priority: it alone raises the fault flag.
                        if (alerta_nivel_baixo) begin
                            falha_q <= 1'b1;
                        end
                        bomba_q     <= 1'b0;
                        concluido_q <= 1'b1;
                        restante_q  <= '0;
                        presc_q     <= '0;
                        pausa_q     <= PAUSA_CNT;
                        estado_q    <= PAUSA;
                    end else begin
                        presc_q <= presc_fim_d ? '0 : presc_q + PW'(1);
                        if (presc_fim_d && (restante_q != 16'd0)) begin
                            restante_q <= restante_q - 16'd1;
                        end
                    end
                end

                PAUSA: begin
                    // Requests, aborts and the alarm are all ignored while resting.
                    if (presc_fim_d) begin
                        presc_q <= '0;
                        if (pausa_q <= 16'd1) begin
                            pausa_q   <= '0;
                            ocupado_q <= 1'b0;
                            estado_q  <= OCIOSO;
                        end else begin
                            pausa_q <= pausa_q - 16'd1;
                        end
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end

                default: begin
                    estado_q   <= OCIOSO;
                    presc_q    <= '0;
                    restante_q <= '0;
                    pausa_q    <= '0;
                    bomba_q    <= 1'b0;
                    ocupado_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bomba_on          = bomba_q;
    assign ocupado           = ocupado_q;
    assign concluido         = concluido_q;
    assign falha             = falha_q;
    assign tempo_restante_ms = restante_q;

endmodule

// File: tb/tb_acionador_bomba.sv
// -----------------------------------------------------------------------------
// tb_acionador_bomba
//
// Directed bench for acionador_bomba with TICKS_POR_MS=10, PAUSA_MS=3,
// TEMPO_MAX_MS=25000. Stimulus pushes the expected outcome of each run into a
// queue; a monitor pops an entry on every concluido pulse and checks the pump
// on-time and fault flag observed for that run.
// -----------------------------------------------------------------------------
module tb_acionador_bomba;

    logic        clk;
    logic        rst_n;
    logic        iniciar;
    logic [15:0] tempo_ms;
    logic        alerta_nivel_baixo;
    logic        abortar;
    logic        bomba_on;
    logic        ocupado;
    logic        concluido;
    logic        falha;
    logic [15:0] tempo_restante_ms;

    acionador_bomba #(
        .TICKS_POR_MS(10),
        .TEMPO_MAX_MS(25000),
        .PAUSA_MS(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .iniciar(iniciar),
        .tempo_ms(tempo_ms),
        .alerta_nivel_baixo(alerta_nivel_baixo),
        .abortar(abortar),
        .bomba_on(bomba_on),
        .ocupado(ocupado),
        .concluido(concluido),
        .falha(falha),
        .tempo_restante_ms(tempo_restante_ms)
    );

    typedef struct {
        int falha;
        int bomba_ciclos;
    } esperado_t;

    esperado_t sb_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int bcnt  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nome, input int atual, input int esperado);
        n_cmp++;
        if (atual !== esperado) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nome, atual, esperado);
        end
    endtask

    // Monitor: counts pump-on cycles and checks each completion pulse.
    initial begin
        esperado_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bcnt = 0;
            end else begin
                if (bomba_on) bcnt++;
                if (concluido) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL concluido_inesperado: got pulse, expected none");
                    end else begin
                        e = sb_q.pop_front();
                        chk("concl_bomba_ciclos", bcnt, e.bomba_ciclos);
                        chk("concl_falha", int'(falha), e.falha);
                        chk("concl_bomba_off", int'(bomba_on), 0);
                    end
                    bcnt = 0;
                end
            end
        end
    end

    task automatic esperar(input int falha_e, input int bomba_e);
        esperado_t e;
        e.falha        = falha_e;
        e.bomba_ciclos = bomba_e;
        sb_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge of the cycle after the start.
    task automatic pulso_inicio(input logic [15:0] t);
        iniciar  = 1'b1;
        tempo_ms = t;
        @(negedge clk);
        iniciar  = 1'b0;
    endtask

    task automatic esperar_ocioso(output int c);
        c = 0;
        while (ocupado && c < 1000) begin
            c++;
            @(negedge clk);
        end
    endtask

    int c;

    initial begin
        rst_n              = 1'b0;
        iniciar            = 1'b0;
        tempo_ms           = 16'd0;
        alerta_nivel_baixo = 1'b0;
        abortar            = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_bomba_on", int'(bomba_on), 0);
        chk("rst_ocupado", int'(ocupado), 0);
        chk("rst_concluido", int'(concluido), 0);
        chk("rst_falha", int'(falha), 0);
        chk("rst_restante", int'(tempo_restante_ms), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // 1. Normal 5 ms run: 50 cycles on, 80 cycles busy.
        esperar(0, 50);
        pulso_inicio(16'd5);
        chk("s1_bomba_on", int'(bomba_on), 1);
        chk("s1_ocupado", int'(ocupado), 1);
        chk("s1_restante", int'(tempo_restante_ms), 5);
        esperar_ocioso(c);
        chk("s1_ocupado_ciclos", c, 80);
        chk("s1_falha", int'(falha), 0);

        // 2. Zero-length start, then start refused by the alarm.
        esperar(0, 0);
        pulso_inicio(16'd0);
        chk("s2_zero_ocupado", int'(ocupado), 0);
        chk("s2_zero_bomba", int'(bomba_on), 0);
        @(negedge clk);
        alerta_nivel_baixo = 1'b1;
        esperar(1, 0);
        pulso_inicio(16'd7);
        chk("s2_recusa_falha", int'(falha), 1);
        chk("s2_recusa_bomba", int'(bomba_on), 0);
        chk("s2_recusa_ocupado", int'(ocupado), 0);
        alerta_nivel_baixo = 1'b0;
        @(negedge clk);
        chk("s2_recusa_bomba2", int'(bomba_on), 0);

        // 3. Interlock raised in RUN cycle 23 of a 10 ms run.
        esperar(1, 23);
        pulso_inicio(16'd10);
        repeat (22) @(negedge clk);
        alerta_nivel_baixo = 1'b1;
        @(negedge clk);
        alerta_nivel_baixo = 1'b0;
        chk("s3_bomba_off", int'(bomba_on), 0);
        chk("s3_falha", int'(falha), 1);
        chk("s3_ocupado", int'(ocupado), 1);
        chk("s3_restante", int'(tempo_restante_ms), 0);
        esperar_ocioso(c);
        chk("s3_pausa_ciclos", c, 30);
        esperar(0, 10);
        pulso_inicio(16'd1);
        chk("s3_falha_limpa", int'(falha), 0);
        esperar_ocioso(c);
        chk("s3_ocupado_1ms", c, 40);

        // 4. Clamp 30000 -> 25000, one decrement per 10 cycles, then abort.
        esperar(0, 21);
        pulso_inicio(16'd30000);
        chk("s4_clamp", int'(tempo_restante_ms), 25000);
        repeat (9) @(negedge clk);
        chk("s4_ciclo10", int'(tempo_restante_ms), 25000);
        @(negedge clk);
        chk("s4_ciclo11", int'(tempo_restante_ms), 24999);
        repeat (10) @(negedge clk);
        chk("s4_ciclo21", int'(tempo_restante_ms), 24998);
        abortar = 1'b1;
        @(negedge clk);
        abortar = 1'b0;
        chk("s4_bomba_off", int'(bomba_on), 0);
        chk("s4_falha", int'(falha), 0);
        esperar_ocioso(c);
        chk("s4_pausa_ciclos", c, 30);

        // 5. Abort during ms 2 of a 5 ms run; requests in PAUSA are dropped.
        esperar(0, 15);
        pulso_inicio(16'd5);
        repeat (14) @(negedge clk);
        chk("s5_restante", int'(tempo_restante_ms), 4);
        abortar = 1'b1;
        @(negedge clk);
        abortar = 1'b0;
        chk("s5_bomba_off", int'(bomba_on), 0);
        chk("s5_falha", int'(falha), 0);
        c = 0;
        while (ocupado && c < 1000) begin
            c++;
            iniciar            = (c == 3 || c == 10 || c == 25);
            tempo_ms           = 16'd5;
            alerta_nivel_baixo = (c == 12);
            abortar            = (c == 18);
            @(negedge clk);
        end
        iniciar            = 1'b0;
        alerta_nivel_baixo = 1'b0;
        abortar            = 1'b0;
        chk("s5_pausa_ciclos", c, 30);
        chk("s5_falha_pausa", int'(falha), 0);
        chk("s5_bomba_pos", int'(bomba_on), 0);
        @(negedge clk);
        chk("s5_ocupado_pos", int'(ocupado), 0);

        // 6. Asynchronous reset between clock edges during RUN.
        pulso_inicio(16'd5);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_rst_bomba", int'(bomba_on), 0);
        chk("s6_rst_ocupado", int'(ocupado), 0);
        chk("s6_rst_concluido", int'(concluido), 0);
        chk("s6_rst_falha", int'(falha), 0);
        chk("s6_rst_restante", int'(tempo_restante_ms), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("s6_pos_bomba", int'(bomba_on), 0);
        chk("s6_pos_ocupado", int'(ocupado), 0);
        esperar(0, 10);
        pulso_inicio(16'd1);
        chk("s6_novo_bomba", int'(bomba_on), 1);
        chk("s6_novo_restante", int'(tempo_restante_ms), 1);
        esperar_ocioso(c);
        chk("s6_novo_ocupado", c, 40);

        repeat (3) @(negedge clk);
        chk("sb_pendentes", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/acionador_bomba.md
# acionador_bomba

Pump actuation stage sitting directly downstream of `sistema_irrigacao`. It accepts the 16-bit irrigation time command `cmd_tempo_bomba_ms` and the low-level alarm. It then drives the physical pump output for exactly the commanded number of milliseconds, derived from the 50 MHz system clock. A safety interlock cuts the pump on low reservoir level, and a mandatory rest interval follows every run.

## Interface
Parameters:
- `TICKS_POR_MS`, 50000: clock cycles per millisecond (50 MHz); benches may override with a small value.
- `TEMPO_MAX_MS`, 25000: clamp ceiling for accepted commands.
- `PAUSA_MS`, 1000: mandatory rest after every run or abort, in ms.

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `iniciar`, in, 1: single-cycle start request.
- `tempo_ms`, in, 16: requested run time in ms; sampled with `iniciar`.
- `alerta_nivel_baixo`, in, 1: low-reservoir alarm; level-sensitive interlock.
- `abortar`, in, 1: operator stop.
- `bomba_on`, out, 1: pump drive, registered.
- `ocupado`, out, 1: high in RUN and PAUSA.
- `concluido`, out, 1: one-cycle pulse at the end of every run, including a zero-length run.
- `falha`, out, 1: sticky interlock fault flag.
- `tempo_restante_ms`, out, 16: remaining ms of the current run; 0 outside RUN.

## Operation
The block is a three-state FSM: OCIOSO → RUN → PAUSA → OCIOSO. Counters:
- Prescaler: width `$clog2(TICKS_POR_MS)`.
- Remaining-ms counter: 16 bits.
- Rest counter: 16 bits, counting ms via the same prescaler.

OCIOSO (`bomba_on`=0, `ocupado`=0):
- `iniciar`=1 with `alerta_nivel_baixo`=1: the request is refused. `falha` is set, `concluido` pulses, and the FSM stays in OCIOSO.
- `iniciar`=1 with `tempo_ms`=0 and no alarm: `concluido` pulses next cycle and the FSM stays in OCIOSO. `falha` is cleared.
- `iniciar`=1 otherwise: latch min(`tempo_ms`, `TEMPO_MAX_MS`) into the remaining counter, clear the prescaler, clear `falha`, and go to RUN.
- The alarm check takes priority over the zero check.

RUN (`bomba_on`=1, `ocupado`=1):
- The prescaler counts 0..`TICKS_POR_MS`-1. At its terminal count the remaining counter decrements.
- Decrement to 0: go to PAUSA and pulse `concluido`.
- `alerta_nivel_baixo`=1 on any cycle: go to PAUSA, set `falha`, pulse `concluido`.
- `abortar`=1: go to PAUSA and pulse `concluido`. `falha` is unchanged.
- If several of these coincide, priority is alarm > abort > natural end.

PAUSA (`bomba_on`=0, `ocupado`=1):
- Counts `PAUSA_MS` ms, then returns to OCIOSO.
- `iniciar` and `abortar` are ignored.
- The alarm has no effect.

Requests while `ocupado`=1 are dropped; they are neither queued nor flagged. `falha` clears only on an accepted start (the zero-length case counts as accepted) or on reset.

## Timing
- Reset (async assert, any state): `bomba_on`=0, `ocupado`=0, `concluido`=0, `falha`=0, `tempo_restante_ms`=0. All counters are cleared and the FSM is in OCIOSO. Deassertion is synchronised by the system reset tree, not by this block.
- `iniciar` sampled high at edge N: `bomba_on`=1 and `ocupado`=1 from cycle N+1, with `tempo_restante_ms` equal to the clamped value.
- Natural run: `bomba_on` is high for exactly T×`TICKS_POR_MS` cycles. `concluido` is high in the first cycle with `bomba_on`=0.
- Interlock or abort sampled at edge M: `bomba_on`=0 from cycle M+1, with `concluido` in that same cycle. Worst-case pump-off latency is 1 cycle.
- PAUSA lasts exactly `PAUSA_MS`×`TICKS_POR_MS` cycles. `ocupado` falls after that, and a new `iniciar` is accepted on the first cycle with `ocupado`=0.
- Zero-length or refused start at edge N: `concluido` in cycle N+1. `ocupado` and `bomba_on` are never asserted.
- Arithmetic: the clamp compares unsigned 16-bit values. The remaining counter never wraps because the decrement is gated at 0. The prescaler wraps to 0 at its terminal count.

## Test plan
All scenarios use `TICKS_POR_MS`=10, `PAUSA_MS`=3, `TEMPO_MAX_MS`=25000.

1. Normal run: `iniciar` with `tempo_ms`=5, alarm 0 → `bomba_on` high for exactly 50 cycles, a single `concluido` pulse, `ocupado` high for 80 cycles, `falha`=0.
2. Zero and refused starts: `iniciar` with `tempo_ms`=0 → `concluido` the next cycle, `bomba_on` never rises. `iniciar` with `tempo_ms`=7 and alarm 1 → `falha`=1, `concluido` pulses, `bomba_on` stays 0.
3. Interlock mid-run: `tempo_ms`=10, alarm raised at cycle 23 of RUN → `bomba_on`=0 the next cycle, `falha`=1, `concluido` pulses, PAUSA of 30 cycles follows. The next valid start clears `falha`.
4. Clamp: `tempo_ms`=30000 → `tempo_restante_ms`=25000 the cycle after the start. Confirm it decrements once every 10 cycles.
5. Abort and busy drop: abort at ms 2 of a 5 ms run → `bomba_on` off the next cycle, `falha`=0. `iniciar` pulses during PAUSA → no effect on state or outputs.
6. Reset mid-run: drop `rst_n` asynchronously between clock edges during RUN → all outputs are 0 immediately (no clock edge required), and the FSM is in OCIOSO after release.
